dm_arbiter: RTL
===============

# dm_arbiter

Two-master arbiter sharing one data-memory SRAM wrapper (single-port, 14-bit word address, 32-bit data, active-low CEB/WEB/BWEB, one-cycle read latency) between the CPU data port (master 0) and a second requester such as a DMA/loader engine (master 1). It sits between the requesters and the DM SRAM wrapper inside the top level. It grants at most one access per cycle, returns read data to the owning master one cycle later, and supports locked back-to-back sequences.

## Interface
- ADDR_W, 14, SRAM word-address width
- DATA_W, 32, data / bit-write-enable width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  access request, held until granted
- m0_we / m1_we  in  1  1 = write, 0 = read (active-high)
- m0_bweb / m1_bweb  in  DATA_W  bit write enable, active-low, writes only
- m0_addr / m1_addr  in  ADDR_W  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_lock / m1_lock  in  1  keep ownership after this access
- m0_gnt / m1_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid, one cycle after read grant
- m0_rdata / m1_rdata  out  DATA_W  read data, valid only with rvalid
- sram_ceb  out  1  SRAM chip enable, active-low
- sram_web  out  1  SRAM write enable, active-low
- sram_bweb  out  DATA_W  SRAM bit write enable, active-low
- sram_a  out  ADDR_W  SRAM address
- sram_di  out  DATA_W  SRAM write data
- sram_do  in  DATA_W  SRAM read data (valid cycle after CEB low with WEB high)

## Operation
- State: owner register {NONE, M0, M1}; priority pointer prio (0/1); read-pending flag rd_pend; read-return id rd_id.
- Grant selection each cycle: if owner = Mx, only Mx may be granted (other master stalls even if owner not requesting). If owner = NONE: single requester wins; both requesting -> winner per arbitration policy (see Configuration).
- Granted master's signals drive SRAM: sram_ceb=0, sram_web=~we, sram_bweb = we ? bweb : all-ones, sram_a=addr, sram_di = we ? wdata : 0.
- No grant: sram_ceb=1, sram_web=1, sram_bweb=all-ones, sram_a=0, sram_di=0.
- Lock: on grant with lock=1 -> owner<=granted master; grant with lock=0 -> owner<=NONE. Owner with req=0 and lock=0 -> owner<=NONE (release without access).
- Read return: grant of read sets rd_pend<=1, rd_id<=master; otherwise rd_pend<=0. Next cycle mX_rvalid = rd_pend & (rd_id==X); mX_rdata = sram_do when valid, else 0.
- Writes produce no rvalid; write data committed at grant edge.
- Both rdata buses are 0 when not valid (no leakage to the other master).

## Timing
- Reset (rst=0, any time): owner=NONE, prio=0, rd_pend=0; all gnt=0 unless req present and rst released; rvalid=0, rdata=0; SRAM outputs idle values. Reset mid-read suppresses the pending rvalid.
- Grant latency 0 cycles (same cycle as req when eligible); read data latency exactly 1 cycle after grant.
- Back-to-back reads by different masters: cycle N M0 granted, N+1 M1 granted and M0 rvalid; N+2 M1 rvalid. Full throughput, one access/cycle.
- Read followed by write same cycle boundary: legal; rvalid for read still appears.
- gnt never asserted without matching req; never both gnt in one cycle.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin. On any non-locked contention resolution prio toggles to the loser; every grant to master X sets prio to the other master. Guarantees M1 service within 2 cycles of contention-free owner state.
- SRAM_ARB_RR_EN undefined: fixed priority, M0 (CPU) always wins contention; prio register removed/tied 0. Lock behaviour unchanged.

## Test plan
- Reset: hold rst=0 with m0_req=1 -> all gnt=0, rvalid=0, sram_ceb=1, sram_bweb=32'hFFFFFFFF; release -> m0_gnt=1 same cycle.
- M0 write addr 14'h0010 data 32'hDEADBEEF bweb 0, then read -> m0_rvalid one cycle after read grant, m0_rdata=32'hDEADBEEF, m1_rvalid=0.
- Both req continuously: RR build -> grants alternate M0,M1,M0,...; fixed build -> M0 every cycle, m1_gnt=0.
- M1 lock=1 for 3 reads addr 0x20..0x22 while M0 requests -> M0 stalled 3 cycles, M1 gets 3 consecutive grants and rvalids; M0 granted the cycle after lock=0 access.
- Partial write bweb=32'hFFFF0000 data 32'h00001234 over 32'hAAAAAAAA -> readback 32'hAAAA1234.
- Read granted then rst asserted before next edge -> no rvalid; after release, rd_pend=0 and owner=NONE.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-master arbiter in front of the single-port DM SRAM wrapper.
// Define SRAM_ARB_RR_EN for round-robin contention; default is fixed M0 priority.
module dm_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_bweb,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_bweb,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [DATA_W-1:0] sram_bweb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } own_e;

    own_e r_owner;
    own_e w_owner_nxt;
    logic r_rd_pend;
    logic r_rd_id;
    logic w_rd_pend_nxt;
    logic w_rd_id_nxt;
    logic w_win1;
    logic w_g0;
    logic w_g1;
    logic w_gnt;
    logic w_we;
    logic w_lock;
    logic w_wr;
    logic [DATA_W-1:0] w_bweb;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_addr;

`ifdef SRAM_ARB_RR_EN
    logic r_prio;
    logic w_prio_nxt;

    assign w_win1 = r_prio;

    always_comb begin
        w_prio_nxt = r_prio;
        if (w_g0) w_prio_nxt = 1'b1;
        if (w_g1) w_prio_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_prio <= 1'b0;
        else      r_prio <= w_prio_nxt;
    end
`else
    assign w_win1 = 1'b0;
`endif

    // Grants are gated by reset so nothing reaches the SRAM while held.
    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (rst) begin
            unique case (r_owner)
                OWN_M0: w_g0 = m0_req;
                OWN_M1: w_g1 = m1_req;
                default: begin
                    w_g0 = m0_req & ~(m1_req & w_win1);
                    w_g1 = m1_req & ~(m0_req & ~w_win1);
                end
            endcase
        end
    end

    assign w_gnt  = w_g0 | w_g1;
    assign m0_gnt = w_g0;
    assign m1_gnt = w_g1;

    always_comb begin
        w_we    = 1'b0;
        w_lock  = 1'b0;
        w_bweb  = '1;
        w_wdata = '0;
        w_addr  = '0;
        unique case (1'b1)
            w_g0: begin
                w_we    = m0_we;
                w_lock  = m0_lock;
                w_bweb  = m0_bweb;
                w_wdata = m0_wdata;
                w_addr  = m0_addr;
            end
            w_g1: begin
                w_we    = m1_we;
                w_lock  = m1_lock;
                w_bweb  = m1_bweb;
                w_wdata = m1_wdata;
                w_addr  = m1_addr;
            end
            default: ;
        endcase
    end

    assign w_wr      = w_gnt & w_we;
    assign sram_ceb  = ~w_gnt;
    assign sram_web  = ~w_wr;
    assign sram_bweb = w_wr ? w_bweb : '1;
    assign sram_a    = w_addr;
    assign sram_di   = w_wr ? w_wdata : '0;

    always_comb begin
        w_owner_nxt   = r_owner;
        w_rd_pend_nxt = w_gnt & ~w_we;
        w_rd_id_nxt   = r_rd_id;
        if (w_gnt) begin
            w_rd_id_nxt = w_g1;
            if (!w_lock)   w_owner_nxt = OWN_NONE;
            else if (w_g1) w_owner_nxt = OWN_M1;
            else           w_owner_nxt = OWN_M0;
        end else begin
            // Idle owner drops the lock without issuing an access.
            unique case (r_owner)
                OWN_M0: begin
                    if (!m0_req && !m0_lock)
                        w_owner_nxt = OWN_NONE;
                end
                OWN_M1: begin
                    if (!m1_req && !m1_lock)
                        w_owner_nxt = OWN_NONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner   <= OWN_NONE;
            r_rd_pend <= 1'b0;
            r_rd_id   <= 1'b0;
        end else begin
            r_owner   <= w_owner_nxt;
            r_rd_pend <= w_rd_pend_nxt;
            r_rd_id   <= w_rd_id_nxt;
        end
    end

    assign m0_rvalid = r_rd_pend & ~r_rd_id;
    assign m1_rvalid = r_rd_pend & r_rd_id;
    assign m0_rdata  = m0_rvalid ? sram_do : '0;
    assign m1_rdata  = m1_rvalid ? sram_do : '0;

endmodule
